// File: rtl/mvu_dma_pkg.sv
// mvu_dma_pkg
//   Shared definitions for the MVU DMA pack engine: FSM state encodings,
//   destination role codes, status-word bit positions and a saturating
//   16-bit increment helper.
//   No ports; imported by the engine top.
package mvu_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dmaState_e;

  typedef enum logic {
    ROLE_DATA   = 1'b0,
    ROLE_WEIGHT = 1'b1
  } dmaRole_e;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ABORT     = 2;
  localparam int unsigned STAT_ZERO_LEN  = 3;
  localparam int unsigned STAT_WORDS_LSB = 16;

  // Word counter shown in the status register sticks at all-ones rather
  // than rolling over, so software never sees a small count after a huge job.
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mvu_dma_pack_engine_if.sv
// mvu_dma_pack_engine_if
//   Bundles the three handshake buses of the DMA pack engine.
//   source_*      : read requests (address/valid out, ready/data in)
//   dest_data_*   : activation RAM writes (address/data/valid out, ready in)
//   dest_weight_* : weight RAM writes (address/data/valid out, ready in)
//   Modport master is the engine side, slave is the memory side.
interface mvu_dma_pack_engine_if #(
  parameter int SRC_DW  = 32,
  parameter int DATA_DW = 64,
  parameter int WGT_DW  = 4096,
  parameter int DATA_AW = 15,
  parameter int WGT_AW  = 9
);

  logic [31:0]        source_address;
  logic               source_valid;
  logic               source_ready;
  logic [SRC_DW-1:0]  source_data;

  logic [DATA_AW-1:0] dest_data_address;
  logic [DATA_DW-1:0] dest_data_data;
  logic               dest_data_valid;
  logic               dest_data_ready;

  logic [WGT_AW-1:0]  dest_weight_address;
  logic [WGT_DW-1:0]  dest_weight_data;
  logic               dest_weight_valid;
  logic               dest_weight_ready;

  modport master (
    output source_address, source_valid,
    input  source_ready, source_data,
    output dest_data_address, dest_data_data, dest_data_valid,
    input  dest_data_ready,
    output dest_weight_address, dest_weight_data, dest_weight_valid,
    input  dest_weight_ready
  );

  modport slave (
    input  source_address, source_valid,
    output source_ready, source_data,
    input  dest_data_address, dest_data_data, dest_data_valid,
    output dest_data_ready,
    input  dest_weight_address, dest_weight_data, dest_weight_valid,
    output dest_weight_ready
  );

endinterface

// File: rtl/mvu_dma_packer.sv
// mvu_dma_packer
//   Shift-in register that assembles SRC_DW-bit beats into a WIDTH-bit word.
//   Each accepted beat enters at the LSB, so the first beat of a word ends up
//   in the most significant slot once target_i beats have arrived.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : empty the register and beat counter (wins over shift_i)
//   shift_i    : accept data_i as the next beat
//   data_i     : incoming beat
//   target_i   : beats that make up a full word for the current role
//   data_o     : packed word
//   count_o    : beats accepted so far
//   full_o     : count_o has reached target_i
module mvu_dma_packer #(
  parameter int WIDTH  = 4096,
  parameter int SRC_DW = 32,
  localparam int MAX_BEATS = WIDTH / SRC_DW,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [SRC_DW-1:0] data_i,
  input  logic [CNT_W-1:0]  target_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == target_i);
  assign data_o  = data_q;
  assign count_o = count_q;

  // Clear takes priority so an abort or a completed write in the same cycle
  // as a stray beat always leaves the packer empty. Beats are refused once
  // full so a word can never be overwritten before it is drained.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear_i) begin
      data_d  = '0;
      count_d = '0;
    end else if (shift_i && !full_o) begin
      data_d  = {data_q[WIDTH-SRC_DW-1:0], data_i};
      count_d = count_q + CNT_W'(1);
    end
  end

  // Packer storage and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mvu_dma_pack_engine.sv
// mvu_dma_pack_engine
//   MVU DMA engine: reads SRC_DW-bit words from the source bus, packs them
//   into DATA_DW (activation) or WGT_DW (weight) words and writes them to the
//   MVU data or weight RAM. Supports source stride, abort, zero-length jobs,
//   sticky status and a one-cycle completion interrupt.
//   clk, rst_n         : clock, synchronous active-low reset
//   cfg_src_addr_i     : source start word address
//   cfg_dst_addr_i     : destination start address (low DATA_AW/WGT_AW bits used)
//   cfg_len_i          : destination words to write
//   cfg_role_i         : 0 = data RAM, 1 = weight RAM
//   cfg_stride_i       : source address step per beat, in words
//   start_i, abort_i   : start pulse, abort request
//   bus                : source / dest data / dest weight handshakes (master)
//   dma_status_o       : [0] busy [1] done [2] aborted [3] zero-len [31:16] words
//   dma_perf_stall_o   : stall-cycle counter
//   dma_irq            : one-cycle completion pulse
//   Macro MVU_DMA_PERF_CNT_EN enables the stall counter; without it the
//   output is tied to zero and no counter flops exist.
module mvu_dma_pack_engine
  import mvu_dma_pkg::*;
#(
  parameter int SRC_DW  = 32,
  parameter int DATA_DW = 64,
  parameter int WGT_DW  = 4096,
  parameter int DATA_AW = 15,
  parameter int WGT_AW  = 9,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cfg_src_addr_i,
  input  logic [31:0]          cfg_dst_addr_i,
  input  logic [LEN_W-1:0]     cfg_len_i,
  input  logic                 cfg_role_i,
  input  logic [7:0]           cfg_stride_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  mvu_dma_pack_engine_if.master bus,
  output logic [31:0]          dma_status_o,
  output logic [31:0]          dma_perf_stall_o,
  output logic                 dma_irq
);

  localparam int DATA_BEATS = DATA_DW / SRC_DW;
  localparam int WGT_BEATS  = WGT_DW / SRC_DW;
  localparam int PACK_W     = (WGT_DW > DATA_DW) ? WGT_DW : DATA_DW;
  localparam int CNT_W      = $clog2(PACK_W / SRC_DW + 1);
  localparam int DST_W      = (DATA_AW > WGT_AW) ? DATA_AW : WGT_AW;

  dmaState_e         state_q, state_d;
  dmaRole_e          role_q, role_d;
  logic [31:0]       srcAddr_q, srcAddr_d;
  logic [DST_W-1:0]  dstPtr_q, dstPtr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        stride_q, stride_d;
  logic [LEN_W-1:0]  wordCnt_q, wordCnt_d;
  logic [15:0]       statWords_q, statWords_d;
  logic              doneFlag_q, doneFlag_d;
  logic              abortFlag_q, abortFlag_d;
  logic              zeroFlag_q, zeroFlag_d;

  logic [PACK_W-1:0] packData;
  logic [CNT_W-1:0]  packCount;
  logic [CNT_W-1:0]  beatTarget;
  logic              packFull;
  logic              packClear;
  logic              srcFire;
  logic              destValid;
  logic              destReady;
  logic              dstFire;
  logic              lastBeat;
  logic [LEN_W-1:0]  wordsAfter;
  logic              unusedDstHi;

  assign unusedDstHi = ^cfg_dst_addr_i[31:DST_W];

  assign beatTarget = (role_q == ROLE_WEIGHT) ? CNT_W'(WGT_BEATS) : CNT_W'(DATA_BEATS);
  assign srcFire    = (state_q == ST_FILL) && bus.source_ready;
  assign lastBeat   = srcFire && (packCount == beatTarget - CNT_W'(1));
  assign destValid  = (state_q == ST_DRAIN) && packFull;
  assign destReady  = (role_q == ROLE_WEIGHT) ? bus.dest_weight_ready : bus.dest_data_ready;
  assign dstFire    = destValid && destReady;
  assign wordsAfter = wordCnt_q + LEN_W'(1);

  mvu_dma_packer #(
    .WIDTH  (PACK_W),
    .SRC_DW (SRC_DW)
  ) uPacker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (packClear),
    .shift_i  (srcFire),
    .data_i   (bus.source_data),
    .target_i (beatTarget),
    .data_o   (packData),
    .count_o  (packCount),
    .full_o   (packFull)
  );

  // Next-state logic. Configuration is captured only when a start is
  // accepted in IDLE, so software may reprogram the CSRs mid-transfer.
  // Abort beats the normal FILL/DRAIN transitions, but a destination write
  // completing in the abort cycle is still counted and advances the pointer.
  always_comb begin
    state_d     = state_q;
    role_d      = role_q;
    srcAddr_d   = srcAddr_q;
    dstPtr_d    = dstPtr_q;
    len_d       = len_q;
    stride_d    = stride_q;
    wordCnt_d   = wordCnt_q;
    statWords_d = statWords_q;
    doneFlag_d  = doneFlag_q;
    abortFlag_d = abortFlag_q;
    zeroFlag_d  = zeroFlag_q;
    packClear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          role_d      = dmaRole_e'(cfg_role_i);
          srcAddr_d   = cfg_src_addr_i;
          dstPtr_d    = cfg_dst_addr_i[DST_W-1:0];
          len_d       = cfg_len_i;
          stride_d    = cfg_stride_i;
          wordCnt_d   = '0;
          statWords_d = '0;
          doneFlag_d  = 1'b0;
          abortFlag_d = 1'b0;
          zeroFlag_d  = 1'b0;
          packClear   = 1'b1;
          if (cfg_len_i == '0) begin
            zeroFlag_d = 1'b1;
            doneFlag_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (srcFire) begin
          srcAddr_d = srcAddr_q + {24'd0, stride_q};
        end
        if (abort_i) begin
          state_d     = ST_IDLE;
          abortFlag_d = 1'b1;
          packClear   = 1'b1;
        end else if (lastBeat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dstFire) begin
          dstPtr_d    = dstPtr_q + DST_W'(1);
          wordCnt_d   = wordsAfter;
          statWords_d = satInc16(statWords_q);
          packClear   = 1'b1;
        end
        if (abort_i) begin
          state_d     = ST_IDLE;
          abortFlag_d = 1'b1;
          packClear   = 1'b1;
        end else if (dstFire) begin
          if (wordsAfter == len_q) begin
            state_d    = ST_DONE;
            doneFlag_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration copies, pointers and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      role_q      <= ROLE_DATA;
      srcAddr_q   <= '0;
      dstPtr_q    <= '0;
      len_q       <= '0;
      stride_q    <= '0;
      wordCnt_q   <= '0;
      statWords_q <= '0;
      doneFlag_q  <= 1'b0;
      abortFlag_q <= 1'b0;
      zeroFlag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      role_q      <= role_d;
      srcAddr_q   <= srcAddr_d;
      dstPtr_q    <= dstPtr_d;
      len_q       <= len_d;
      stride_q    <= stride_d;
      wordCnt_q   <= wordCnt_d;
      statWords_q <= statWords_d;
      doneFlag_q  <= doneFlag_d;
      abortFlag_q <= abortFlag_d;
      zeroFlag_q  <= zeroFlag_d;
    end
  end

  // Bus outputs are gated by state and role so that idle buses always read
  // as zero and only the selected RAM ever sees a write request.
  always_comb begin
    bus.source_valid        = (state_q == ST_FILL);
    bus.source_address      = (state_q == ST_FILL) ? srcAddr_q : 32'd0;
    bus.dest_data_valid     = destValid && (role_q == ROLE_DATA);
    bus.dest_data_address   = bus.dest_data_valid ? dstPtr_q[DATA_AW-1:0] : '0;
    bus.dest_data_data      = bus.dest_data_valid ? packData[DATA_DW-1:0] : '0;
    bus.dest_weight_valid   = destValid && (role_q == ROLE_WEIGHT);
    bus.dest_weight_address = bus.dest_weight_valid ? dstPtr_q[WGT_AW-1:0] : '0;
    bus.dest_weight_data    = bus.dest_weight_valid ? packData[WGT_DW-1:0] : '0;
  end

  // Status word assembly and the completion pulse.
  always_comb begin
    dma_status_o                             = '0;
    dma_status_o[STAT_BUSY]                  = (state_q != ST_IDLE);
    dma_status_o[STAT_DONE]                  = doneFlag_q;
    dma_status_o[STAT_ABORT]                 = abortFlag_q;
    dma_status_o[STAT_ZERO_LEN]              = zeroFlag_q;
    dma_status_o[STAT_WORDS_LSB +: 16]       = statWords_q;
    dma_irq                                  = (state_q == ST_DONE);
  end

`ifdef MVU_DMA_PERF_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;
  logic        stallNow;

  // A stall is any cycle in which the engine offers a transfer that the far
  // side does not take. The counter restarts with each accepted start.
  always_comb begin
    stallNow   = ((state_q == ST_FILL) && !bus.source_ready) || (destValid && !destReady);
    stallCnt_d = stallCnt_q;
    if ((state_q == ST_IDLE) && start_i) begin
      stallCnt_d = '0;
    end else if (stallNow && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign dma_perf_stall_o = stallCnt_q;
`else
  assign dma_perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_mvu_dma_pack_engine.sv
// tb_mvu_dma_pack_engine
//   Directed bench for mvu_dma_pack_engine: data and weight transfers,
//   address wrap, zero length, stride with back-pressure, abort and reset
//   mid-transfer. Source memory returns {addr[15:0], ~addr[15:0]}.
//   Honours MVU_DMA_PERF_CNT_EN when computing the expected stall count.
module tb_mvu_dma_pack_engine;

  localparam int SRC_DW  = 32;
  localparam int DATA_DW = 64;
  localparam int WGT_DW  = 4096;
  localparam int DATA_AW = 15;
  localparam int WGT_AW  = 9;
  localparam int LEN_W   = 16;

`ifdef MVU_DMA_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       cfgSrc, cfgDst;
  logic [LEN_W-1:0]  cfgLen;
  logic              cfgRole;
  logic [7:0]        cfgStride;
  logic              start, abortReq;
  logic [31:0]       status, perf;
  logic              irq;

  int testsRun    = 0;
  int testsFailed = 0;

  mvu_dma_pack_engine_if #(
    .SRC_DW(SRC_DW), .DATA_DW(DATA_DW), .WGT_DW(WGT_DW),
    .DATA_AW(DATA_AW), .WGT_AW(WGT_AW)
  ) bus ();

  mvu_dma_pack_engine #(
    .SRC_DW(SRC_DW), .DATA_DW(DATA_DW), .WGT_DW(WGT_DW),
    .DATA_AW(DATA_AW), .WGT_AW(WGT_AW), .LEN_W(LEN_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_src_addr_i   (cfgSrc),
    .cfg_dst_addr_i   (cfgDst),
    .cfg_len_i        (cfgLen),
    .cfg_role_i       (cfgRole),
    .cfg_stride_i     (cfgStride),
    .start_i          (start),
    .abort_i          (abortReq),
    .bus              (bus),
    .dma_status_o     (status),
    .dma_perf_stall_o (perf),
    .dma_irq          (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] srcWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.source_data = srcWord(bus.source_address);

  // Memory-side slaves: each request is held off for a programmable number
  // of cycles before ready is given for exactly one handshake.
  int srcStall = 0;
  int dstStall = 0;
  int srcWait  = 0;
  int dstWait  = 0;
  always @(posedge clk) begin
    #1;
    if (bus.source_valid && srcWait < srcStall) begin
      bus.source_ready = 1'b0;
      srcWait++;
    end else if (bus.source_valid) begin
      bus.source_ready = 1'b1;
      srcWait = 0;
    end else begin
      bus.source_ready = 1'b0;
      srcWait = 0;
    end
    if ((bus.dest_data_valid || bus.dest_weight_valid) && dstWait < dstStall) begin
      bus.dest_data_ready   = 1'b0;
      bus.dest_weight_ready = 1'b0;
      dstWait++;
    end else begin
      bus.dest_data_ready   = 1'b1;
      bus.dest_weight_ready = 1'b1;
      dstWait = 0;
    end
  end

  // Monitor: logs every handshake and pulse, sampled mid-cycle.
  logic [31:0] srcAddrQ[$];
  logic [31:0] dstAddrQ[$];
  logic [63:0] dataQ[$];
  logic [63:0] wgtHiQ[$];
  logic [63:0] wgtLoQ[$];
  int srcValidCnt = 0, dataValidCnt = 0, wgtValidCnt = 0;
  int irqCnt = 0, irqCycle = 0, cycleNum = 0;

  always @(posedge clk) cycleNum++;

  always @(negedge clk) begin
    if (bus.source_valid) srcValidCnt++;
    if (bus.dest_data_valid) dataValidCnt++;
    if (bus.dest_weight_valid) wgtValidCnt++;
    if (bus.source_valid && bus.source_ready) srcAddrQ.push_back(bus.source_address);
    if (bus.dest_data_valid && bus.dest_data_ready) begin
      dstAddrQ.push_back({17'd0, bus.dest_data_address});
      dataQ.push_back(bus.dest_data_data);
    end
    if (bus.dest_weight_valid && bus.dest_weight_ready) begin
      dstAddrQ.push_back({23'd0, bus.dest_weight_address});
      wgtHiQ.push_back(bus.dest_weight_data[WGT_DW-1 -: 64]);
      wgtLoQ.push_back(bus.dest_weight_data[63:0]);
    end
    if (irq) begin
      irqCnt++;
      irqCycle = cycleNum;
    end
  end

  int srcBase, dstBase, dataBase, wgtBase;
  int srcValidBase, dataValidBase, wgtValidBase, irqBase, startCycle;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start with the given configuration, then scrambles the CSRs to
  // show that the running job is unaffected.
  task automatic applyStimulus(input logic role, input logic [LEN_W-1:0] len,
                               input logic [31:0] src, input logic [31:0] dst,
                               input logic [7:0] stride, input int sStall, input int dStall);
    srcStall = sStall;
    dstStall = dStall;
    @(posedge clk); #1;
    cfgRole = role; cfgLen = len; cfgSrc = src; cfgDst = dst; cfgStride = stride;
    start = 1'b1;
    startCycle    = cycleNum;
    srcBase       = srcAddrQ.size();
    dstBase       = dstAddrQ.size();
    dataBase      = dataQ.size();
    wgtBase       = wgtHiQ.size();
    srcValidBase  = srcValidCnt;
    dataValidBase = dataValidCnt;
    wgtValidBase  = wgtValidCnt;
    irqBase       = irqCnt;
    @(posedge clk); #1;
    start = 1'b0;
    cfgRole = ~role; cfgLen = len + 16'd5; cfgSrc = 32'hDEAD_0000; cfgDst = 32'h55; cfgStride = 8'd9;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (status[0] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busyCleared", 64'(status[0]), 64'd0);
  endtask

  // Three activation words from 0x100 to 0x10, no back-pressure.
  task automatic runBasic(input string name);
    applyStimulus(1'b0, 16'd3, 32'h100, 32'h10, 8'd1, 0, 0);
    waitIdle(200);
    checkOutput({name, ":nReads"}, 64'(srcAddrQ.size() - srcBase), 64'd6);
    for (int i = 0; i < 6 && srcBase + i < srcAddrQ.size(); i++)
      checkOutput($sformatf("%s:srcAddr%0d", name, i), 64'(srcAddrQ[srcBase+i]), 64'(32'h100 + i));
    checkOutput({name, ":nWrites"}, 64'(dataQ.size() - dataBase), 64'd3);
    for (int i = 0; i < 3 && dataBase + i < dataQ.size(); i++) begin
      checkOutput($sformatf("%s:dstAddr%0d", name, i), 64'(dstAddrQ[dstBase+i]), 64'(32'h10 + i));
      checkOutput($sformatf("%s:word%0d", name, i), dataQ[dataBase+i],
                  {srcWord(32'h100 + 2*i), srcWord(32'h101 + 2*i)});
    end
    checkOutput({name, ":wgtValid"}, 64'(wgtValidCnt - wgtValidBase), 64'd0);
    checkOutput({name, ":irqCount"}, 64'(irqCnt - irqBase), 64'd1);
    checkOutput({name, ":status"}, 64'(status), 64'h0003_0002);
    checkOutput({name, ":perf"}, 64'(perf), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abortReq = 1'b0;
    cfgSrc = '0; cfgDst = '0; cfgLen = '0; cfgRole = 1'b0; cfgStride = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst:status", 64'(status), 64'd0);
    checkOutput("rst:perf", 64'(perf), 64'd0);
    checkOutput("rst:irq", 64'(irq), 64'd0);
    checkOutput("rst:valids", 64'({bus.source_valid, bus.dest_data_valid, bus.dest_weight_valid}), 64'd0);
    rst_n = 1'b1;

    // Basic activation transfer.
    runBasic("t1");

    // Weight role, destination pointer wraps from 0x1FF to 0x000.
    applyStimulus(1'b1, 16'd2, 32'h200, 32'h1FF, 8'd1, 0, 0);
    waitIdle(1000);
    checkOutput("t2:nReads", 64'(srcAddrQ.size() - srcBase), 64'd256);
    if (srcAddrQ.size() >= srcBase + 256)
      checkOutput("t2:lastRead", 64'(srcAddrQ[srcBase+255]), 64'h2FF);
    checkOutput("t2:nWrites", 64'(wgtHiQ.size() - wgtBase), 64'd2);
    if (wgtHiQ.size() >= wgtBase + 2) begin
      checkOutput("t2:dstAddr0", 64'(dstAddrQ[dstBase]), 64'h1FF);
      checkOutput("t2:dstAddr1", 64'(dstAddrQ[dstBase+1]), 64'h000);
      checkOutput("t2:w0hi", wgtHiQ[wgtBase],   {srcWord(32'h200), srcWord(32'h201)});
      checkOutput("t2:w0lo", wgtLoQ[wgtBase],   {srcWord(32'h27E), srcWord(32'h27F)});
      checkOutput("t2:w1hi", wgtHiQ[wgtBase+1], {srcWord(32'h280), srcWord(32'h281)});
      checkOutput("t2:w1lo", wgtLoQ[wgtBase+1], {srcWord(32'h2FE), srcWord(32'h2FF)});
    end
    checkOutput("t2:dataValid", 64'(dataValidCnt - dataValidBase), 64'd0);
    checkOutput("t2:irqCount", 64'(irqCnt - irqBase), 64'd1);
    checkOutput("t2:status", 64'(status), 64'h0002_0002);

    // Zero-length job.
    applyStimulus(1'b0, 16'd0, 32'h400, 32'h0, 8'd1, 0, 0);
    waitIdle(20);
    checkOutput("t3:srcValid", 64'(srcValidCnt - srcValidBase), 64'd0);
    checkOutput("t3:destValid", 64'((dataValidCnt - dataValidBase) + (wgtValidCnt - wgtValidBase)), 64'd0);
    checkOutput("t3:irqCount", 64'(irqCnt - irqBase), 64'd1);
    checkOutput("t3:irqDelay", 64'(irqCycle - startCycle), 64'd1);
    checkOutput("t3:status", 64'(status), 64'h0000_000A);

    // Stride 4 with back-pressure: 2 stall cycles per beat, 1 per word.
    applyStimulus(1'b0, 16'd2, 32'h0, 32'h7FFF, 8'd4, 2, 1);
    waitIdle(500);
    checkOutput("t4:nReads", 64'(srcAddrQ.size() - srcBase), 64'd4);
    for (int i = 0; i < 4 && srcBase + i < srcAddrQ.size(); i++)
      checkOutput($sformatf("t4:srcAddr%0d", i), 64'(srcAddrQ[srcBase+i]), 64'(4*i));
    checkOutput("t4:nWrites", 64'(dataQ.size() - dataBase), 64'd2);
    if (dataQ.size() >= dataBase + 2) begin
      checkOutput("t4:dstAddr0", 64'(dstAddrQ[dstBase]), 64'h7FFF);
      checkOutput("t4:dstAddr1", 64'(dstAddrQ[dstBase+1]), 64'h0000);
      checkOutput("t4:word0", dataQ[dataBase],   {srcWord(32'd0), srcWord(32'd4)});
      checkOutput("t4:word1", dataQ[dataBase+1], {srcWord(32'd8), srcWord(32'd12)});
    end
    checkOutput("t4:status", 64'(status), 64'h0002_0002);
    checkOutput("t4:perfStall", 64'(perf), PERF_ON ? 64'd10 : 64'd0);

    // Abort while filling the second word of a four-word job.
    applyStimulus(1'b0, 16'd4, 32'h300, 32'h20, 8'd1, 0, 0);
    begin
      int n = 0;
      while (srcAddrQ.size() - srcBase < 3 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("t5:readsBeforeAbort", 64'(srcAddrQ.size() - srcBase), 64'd3);
    abortReq = 1'b1;
    @(posedge clk); #1;
    abortReq = 1'b0;
    checkOutput("t5:status", 64'(status), 64'h0001_0004);
    checkOutput("t5:srcValid", 64'(bus.source_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5:nWrites", 64'(dataQ.size() - dataBase), 64'd1);
    checkOutput("t5:nReads", 64'(srcAddrQ.size() - srcBase), 64'd4);
    checkOutput("t5:irqCount", 64'(irqCnt - irqBase), 64'd0);
    runBasic("t5restart");

    // Reset while a word is waiting in DRAIN.
    applyStimulus(1'b0, 16'd3, 32'h100, 32'h10, 8'd1, 0, 3);
    begin
      int n = 0;
      while (!bus.dest_data_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("t6:drainReached", 64'(bus.dest_data_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6:status", 64'(status), 64'd0);
    checkOutput("t6:perf", 64'(perf), 64'd0);
    checkOutput("t6:irq", 64'(irq), 64'd0);
    checkOutput("t6:valids", 64'({bus.source_valid, bus.dest_data_valid, bus.dest_weight_valid}), 64'd0);
    checkOutput("t6:addrs", 64'(bus.source_address | {17'd0, bus.dest_data_address} |
                                {23'd0, bus.dest_weight_address}), 64'd0);
    checkOutput("t6:data", 64'({|bus.dest_data_data, |bus.dest_weight_data}), 64'd0);
    rst_n = 1'b1;
    runBasic("t6postReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
